uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_arb_pkg.sv | 7 +
 rtl/rr_pick.sv | 23 ++
 rtl/uart_tx_arb.sv | 109 ++++++++++
 tb/tb_uart_tx_arb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and defaults for the UART TX arbiter
package uart_arb_pkg;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_TIMEOUT = 255;
  localparam int IDLE_W = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector starting just after the last winner
module rr_pick #(
  parameter int N = 4,
  parameter int LGW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [LGW-1:0] i_last,
  output logic [N-1:0]   o_gnt,
  output logic           o_valid
);
  localparam logic [N-1:0] ONE = N'(1);
  logic [N-1:0] w_bit;
  // scan farthest offset first so the nearest requester after i_last overrides
  always_comb begin
    o_gnt = '0;
    w_bit = '0;
    for (int k = N; k >= 1; k--) begin
      w_bit = ONE << ((int'(i_last) + k) % N);
      o_gnt = |(i_req & w_bit) ? w_bit : o_gnt;
    end
  end
  assign o_valid = |i_req;
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: locks one byte-stream requester per packet onto the UART TX FIFO
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              fifo_wr,
  output logic [7:0]        fifo_wdata,
  input  logic              fifo_full,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              pkt_done,
  output logic              pkt_abort
);
  localparam int LGW = $clog2(NREQ);
  state_t r_state, w_state;
  logic [NREQ-1:0] r_grant, w_grant, w_pick;
  logic [LGW-1:0] r_last, w_last, w_pick_idx;
  logic [IDLE_W-1:0] r_idle, w_idle;
  logic r_done, r_abort, w_done, w_abort;
  logic w_xfer, w_own_valid, w_own_last, w_pick_valid, w_timeout;
  logic [7:0] w_own_data;

  rr_pick #(.N(NREQ), .LGW(LGW)) u_pick (
    .i_req   (req_valid),
    .i_last  (r_last),
    .o_gnt   (w_pick),
    .o_valid (w_pick_valid)
  );

  assign w_xfer = r_state == XFER;
  assign w_own_valid = |(req_valid & r_grant);
  assign w_own_last = |(req_last & r_grant);
  assign w_timeout = w_xfer && r_idle == IDLE_W'(TIMEOUT);
  assign req_ready = (w_xfer && !fifo_full && !w_timeout) ? r_grant : '0;
  assign fifo_wr = w_xfer & w_own_valid & ~fifo_full & ~w_timeout;
  assign fifo_wdata = w_xfer ? w_own_data : 8'h00;
  assign grant = r_grant;
  assign busy = w_xfer;
  assign pkt_done = r_done;
  assign pkt_abort = r_abort;

  // owner byte mux and index of the arbitration winner
  always_comb begin
    w_own_data = '0;
    w_pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_own_data = r_grant[k] ? req_data[8*k +: 8] : w_own_data;
      w_pick_idx = w_pick[k] ? LGW'(k) : w_pick_idx;
    end
  end

  // next state: grant from IDLE, release on the last byte or on owner idleness
  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_last = r_last;
    w_idle = r_idle;
    w_done = 1'b0;
    w_abort = 1'b0;
    if (!w_xfer) begin
      if (en && w_pick_valid) begin
        w_state = XFER;
        w_grant = w_pick;
        w_last = w_pick_idx;
        w_idle = '0;
      end
    end else if (fifo_wr && w_own_last) begin
      w_state = IDLE;
      w_grant = '0;
      w_idle = '0;
      w_done = 1'b1;
    end else if (w_timeout) begin
      w_state = IDLE;
      w_grant = '0;
      w_idle = '0;
      w_abort = 1'b1;
    end else begin
      w_idle = (w_own_valid || fifo_full) ? '0 : r_idle + IDLE_W'(1);
    end
  end

  // state and lock registers; reset drops any lock without a completion pulse
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last <= LGW'(NREQ - 1);
      r_idle <= '0;
      r_done <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_last <= w_last;
      r_idle <= w_idle;
      r_done <= w_done;
      r_abort <= w_abort;
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed checks of arbitration, packet lock, backpressure, timeout and reset
module tb_uart_tx_arb;
  localparam int N = 4;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b1;
  logic en = 1'b0;
  logic fifo_full = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_ready, grant;
  logic fifo_wr, busy, pkt_done, pkt_abort;
  logic [7:0] fifo_wdata;
  int n_tests = 0;
  int n_fail = 0;

  uart_tx_arb #(.NREQ(N), .TIMEOUT(10)) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .en         (en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .grant      (grant),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .pkt_abort  (pkt_abort)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge PCLK);
    #2;
  endtask

  task automatic test_reset;
    #1 PRESETn = 1'b0;
    en = 1'b1;
    req_valid = 4'b1111;
    repeat (2) tick();
    n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b exp 0000", grant); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b exp 0000", req_ready); end
    n_tests++; if (fifo_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr: got %b exp 0", fifo_wr); end
    n_tests++; if (fifo_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_wdata: got %h exp 00", fifo_wdata); end
    n_tests++; if ({pkt_done, pkt_abort} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got %b exp 00", {pkt_done, pkt_abort}); end
    req_valid = '0;
    PRESETn = 1'b1;
  endtask

  task automatic test_grant;
    req_valid = 4'b1111;
    req_data = 32'h44434241;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b exp 0", busy); end
    n_tests++; if (fifo_wr !== 1'b0) begin n_fail++; $display("FAIL idle_wr: got %b exp 0", fifo_wr); end
    tick();
    n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL first_grant: got %b exp 0001", grant); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b exp 1", busy); end
    n_tests++; if (fifo_wr !== 1'b1) begin n_fail++; $display("FAIL byte0_wr: got %b exp 1", fifo_wr); end
    n_tests++; if (fifo_wdata !== 8'h41) begin n_fail++; $display("FAIL byte0_data: got %h exp 41", fifo_wdata); end
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL byte0_ready: got %b exp 0001", req_ready); end
  endtask

  task automatic test_packet;
    tick();
    req_data[7:0] = 8'h42;
    req_last = 4'b0001;
    #1;
    n_tests++; if (fifo_wr !== 1'b1) begin n_fail++; $display("FAIL byte1_wr: got %b exp 1", fifo_wr); end
    n_tests++; if (fifo_wdata !== 8'h42) begin n_fail++; $display("FAIL byte1_data: got %h exp 42", fifo_wdata); end
    tick();
    req_last = '0;
    req_valid = 4'b1110;
    #1;
    n_tests++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL pkt_done: got %b exp 1", pkt_done); end
    n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL release_grant: got %b exp 0000", grant); end
    n_tests++; if ({busy, fifo_wr, req_ready} !== 6'b0) begin n_fail++; $display("FAIL release_idle: got %b exp 000000", {busy, fifo_wr, req_ready}); end
    n_tests++; if (fifo_wdata !== 8'h00) begin n_fail++; $display("FAIL release_wdata: got %h exp 00", fifo_wdata); end
    tick();
    n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rr_next: got %b exp 0010", grant); end
    n_tests++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b exp 0", pkt_done); end
  endtask

  task automatic test_backpressure;
    int bad;
    bad = 0;
    req_data[15:8] = 8'h55;
    req_valid = 4'b0010;
    fifo_full = 1'b1;
    #1;
    repeat (300) begin
      if (fifo_wr !== 1'b0 || req_ready !== 4'b0000 || pkt_abort !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL full_hold: got %0d bad cycles exp 0", bad); end
    fifo_full = 1'b0;
    req_last = 4'b0010;
    #1;
    n_tests++; if (fifo_wr !== 1'b1) begin n_fail++; $display("FAIL full_drop_wr: got %b exp 1", fifo_wr); end
    n_tests++; if (fifo_wdata !== 8'h55) begin n_fail++; $display("FAIL full_drop_data: got %h exp 55", fifo_wdata); end
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL full_drop_ready: got %b exp 0010", req_ready); end
    tick();
    req_last = '0;
    req_valid = '0;
    #1;
    n_tests++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL full_pkt_done: got %b exp 1", pkt_done); end
  endtask

  task automatic test_timeout;
    int first;
    first = 0;
    req_valid = 4'b0100;
    tick();
    n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL to_grant: got %b exp 0100", grant); end
    req_valid = 4'b1000;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      tick();
      if (pkt_abort === 1'b1) first = i;
    end
    n_tests++; if (first !== 11) begin n_fail++; $display("FAIL to_abort_cycle: got %0d exp 11", first); end
    n_tests++; if ({grant, busy, pkt_done} !== 6'b0) begin n_fail++; $display("FAIL to_release: got %b exp 000000", {grant, busy, pkt_done}); end
    tick();
    n_tests++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL to_next_grant: got %b exp 1000", grant); end
    n_tests++; if (pkt_abort !== 1'b0) begin n_fail++; $display("FAIL abort_pulse_width: got %b exp 0", pkt_abort); end
  endtask

  task automatic test_en_drop;
    int bad;
    bad = 0;
    en = 1'b0;
    req_data[31:24] = 8'h77;
    req_last = 4'b1000;
    req_valid = 4'b1001;
    #1;
    n_tests++; if (fifo_wr !== 1'b1) begin n_fail++; $display("FAIL en0_wr: got %b exp 1", fifo_wr); end
    n_tests++; if (fifo_wdata !== 8'h77) begin n_fail++; $display("FAIL en0_data: got %h exp 77", fifo_wdata); end
    tick();
    req_last = '0;
    req_valid = 4'b0001;
    #1;
    n_tests++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL en0_done: got %b exp 1", pkt_done); end
    repeat (3) begin
      tick();
      if (grant !== 4'b0000 || busy !== 1'b0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL en0_no_grant: got %0d bad cycles exp 0", bad); end
    en = 1'b1;
    tick();
    n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL en1_grant: got %b exp 0001", grant); end
  endtask

  task automatic test_back_to_back;
    req_data[7:0] = 8'h99;
    req_last = 4'b0001;
    req_valid = 4'b0001;
    #1;
    n_tests++; if (fifo_wdata !== 8'h99) begin n_fail++; $display("FAIL single_data: got %h exp 99", fifo_wdata); end
    tick();
    n_tests++; if ({pkt_done, busy} !== 2'b10) begin n_fail++; $display("FAIL single_done: got %b exp 10", {pkt_done, busy}); end
    tick();
    n_tests++; if ({grant, busy} !== 5'b00011) begin n_fail++; $display("FAIL single_regrant: got %b exp 00011", {grant, busy}); end
  endtask

  task automatic test_reset_mid;
    req_last = '0;
    req_valid = 4'b0011;
    #1;
    PRESETn = 1'b0;
    #1;
    n_tests++; if ({grant, busy, fifo_wr, req_ready} !== 10'b0) begin n_fail++; $display("FAIL mid_rst_outs: got %b exp 0000000000", {grant, busy, fifo_wr, req_ready}); end
    n_tests++; if (fifo_wdata !== 8'h00) begin n_fail++; $display("FAIL mid_rst_wdata: got %h exp 00", fifo_wdata); end
    tick();
    n_tests++; if ({pkt_done, pkt_abort} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_pulses: got %b exp 00", {pkt_done, pkt_abort}); end
    PRESETn = 1'b1;
    tick();
    n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL mid_rst_priority: got %b exp 0001", grant); end
  endtask

  initial begin
    test_reset();
    test_grant();
    test_packet();
    test_backpressure();
    test_timeout();
    test_en_drop();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
